// File: rtl/mb_addr_tracker_pkg.sv
// mb_addr_tracker_pkg: symbol codes, FSM encodings and width defaults shared by mb_addr_tracker.
package mb_addr_tracker_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int POS_W_DEF = 7;
    localparam logic [5:0] MBAI_ESCAPE = 6'd34;
    localparam logic [5:0] MBAI_STUFF = 6'd35;
    localparam logic [5:0] MBAI_ESC_INCR = 6'd33;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_WRAP = 3'd4;
    localparam logic [2:0] S_VALID = 3'd5;
endpackage

// File: rtl/mb_addr_tracker_pos_counter.sv
// mb_pos_counter: macroblock row/column counter; one column step per cycle, wrapping to the next row at the picture width.
module mb_pos_counter #(
    parameter int POS_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [POS_W-1:0] load_row,
    input  logic [POS_W-1:0] width,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col
);
    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    logic wrap;
    always_comb begin
        wrap = col_q + POS_W'(1) == width;
        row_d = load ? load_row : (step && wrap) ? row_q + POS_W'(1) : row_q;
        col_d = load ? '0 : step ? (wrap ? '0 : col_q + POS_W'(1)) : col_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
    assign row = row_q;
    assign col = col_q;
endmodule

// File: rtl/mb_addr_tracker.sv
// mb_addr_tracker: drives the MB address-increment VLC walker and tracks MB address/row/col and skip count.
// MB_ADDR_RANGE_CHECK_EN adds a picture-size range check with sticky error and address clamp.
module mb_addr_tracker
    import mb_addr_tracker_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Slice_Start_I,
    input  logic [7:0]        Slice_Vert_Pos_I,
    input  logic [POS_W-1:0]  MB_Width_I,
    input  logic [ADDR_W-1:0] Pic_MB_Count_I,
    input  logic              Incr_Req_I,
    output logic              Incr_Start_O,
    input  logic              Valid_Code_I,
    input  logic [7:0]        Symbol_I,
    output logic [ADDR_W-1:0] MB_Addr_O,
    output logic [POS_W-1:0]  MB_Row_O,
    output logic [POS_W-1:0]  MB_Col_O,
    output logic [ADDR_W-1:0] Skip_Count_O,
    output logic              Addr_Valid_O,
    input  logic              Addr_Ack_I,
    output logic              Addr_Err_O
);
    logic [2:0] state_q, state_d;
    logic first_q, first_d, err_q, err_d;
    logic [ADDR_W-1:0] acc_q, acc_d, base_q, base_d, addr_q, addr_d, skip_q, skip_d, wrap_q, wrap_d;
    logic [ADDR_W-1:0] eff, vm1;
    logic [ADDR_W:0] acc_sum, addr_sum;
    logic [5:0] val;
    logic illegal, step, unused_ok;
    always_comb begin
        val = Symbol_I[5:0];
        illegal = val == 6'd0 || val > MBAI_STUFF;
        eff = val == MBAI_ESCAPE ? ADDR_W'(MBAI_ESC_INCR) : val == MBAI_STUFF ? '0 : illegal ? ADDR_W'(1) : ADDR_W'(val);
        acc_sum = {1'b0, acc_q} + {1'b0, eff};
        addr_sum = first_q ? {1'b0, base_q} + {1'b0, acc_q} - (ADDR_W+1)'(1) : {1'b0, addr_q} + {1'b0, acc_q};
        vm1 = ADDR_W'(Slice_Vert_Pos_I) - ADDR_W'(1);
        state_d = state_q;
        first_d = first_q;
        err_d = err_q;
        acc_d = acc_q;
        base_d = base_q;
        addr_d = addr_q;
        skip_d = skip_q;
        wrap_d = wrap_q;
        step = 1'b0;
        case (state_q)
            S_IDLE: state_d = Incr_Req_I ? S_START : S_IDLE;
            S_START: state_d = S_WAIT;
            S_WAIT: if (Valid_Code_I) begin
                acc_d = acc_sum[ADDR_W] ? '1 : acc_sum[ADDR_W-1:0];
                err_d = err_q | illegal;
                state_d = (val == MBAI_ESCAPE || val == MBAI_STUFF) ? S_START : S_CALC;
            end
            S_CALC: begin
                addr_d = addr_sum[ADDR_W] ? '1 : addr_sum[ADDR_W-1:0];
`ifdef MB_ADDR_RANGE_CHECK_EN
                if (addr_sum >= {1'b0, Pic_MB_Count_I}) begin
                    addr_d = Pic_MB_Count_I - ADDR_W'(1);
                    err_d = 1'b1;
                end
`endif
                skip_d = first_q ? '0 : acc_q - ADDR_W'(1);
                // the first MB of a slice starts at column 0, so it takes one step fewer
                step = !first_q;
                wrap_d = acc_q - ADDR_W'(1);
                state_d = acc_q == ADDR_W'(1) ? S_VALID : S_WRAP;
            end
            S_WRAP: begin
                step = 1'b1;
                wrap_d = wrap_q - ADDR_W'(1);
                state_d = wrap_q == ADDR_W'(1) ? S_VALID : S_WRAP;
            end
            S_VALID: if (Addr_Ack_I) begin
                first_d = 1'b0;
                acc_d = '0;
                state_d = Incr_Req_I ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (Slice_Start_I) begin
            state_d = S_IDLE;
            first_d = 1'b1;
            err_d = 1'b0;
            acc_d = '0;
            base_d = vm1 * ADDR_W'(MB_Width_I);
            step = 1'b0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            first_q <= 1'b1;
            err_q <= 1'b0;
            acc_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            skip_q <= '0;
            wrap_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            err_q <= err_d;
            acc_q <= acc_d;
            base_q <= base_d;
            addr_q <= addr_d;
            skip_q <= skip_d;
            wrap_q <= wrap_d;
        end
    end
    mb_pos_counter #(.POS_W(POS_W)) u_pos (
        .clock(clock),
        .reset(reset),
        .load(Slice_Start_I),
        .step(step),
        .load_row(POS_W'(Slice_Vert_Pos_I - 8'd1)),
        .width(MB_Width_I),
        .row(MB_Row_O),
        .col(MB_Col_O)
    );
`ifdef MB_ADDR_RANGE_CHECK_EN
    assign unused_ok = ^Symbol_I[7:6];
`else
    assign unused_ok = ^{Symbol_I[7:6], Pic_MB_Count_I};
`endif
    assign Incr_Start_O = state_q == S_START;
    assign Addr_Valid_O = state_q == S_VALID;
    assign MB_Addr_O = addr_q;
    assign Skip_Count_O = skip_q;
    assign Addr_Err_O = err_q;
endmodule

// File: tb/tb_mb_addr_tracker.sv
// tb_mb_addr_tracker: directed vectors with an arithmetic address/row/col model and hand-computed pins.
module tb_mb_addr_tracker;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic Slice_Start_I = 1'b0;
    logic [7:0] Slice_Vert_Pos_I = '0;
    logic [6:0] MB_Width_I = '0;
    logic [13:0] Pic_MB_Count_I = '0;
    logic Incr_Req_I = 1'b0;
    logic Incr_Start_O;
    logic Valid_Code_I = 1'b0;
    logic [7:0] Symbol_I = '0;
    logic [13:0] MB_Addr_O;
    logic [6:0] MB_Row_O;
    logic [6:0] MB_Col_O;
    logic [13:0] Skip_Count_O;
    logic Addr_Valid_O;
    logic Addr_Ack_I = 1'b0;
    logic Addr_Err_O;
    int total = 0;
    int bad = 0;
    int starts = 0;
    int m_addr = 0, m_width = 45, m_vpos = 1, m_pic = 8160;
    int exp_row = 0, exp_col = 0, exp_skip = 0;
    bit m_first = 1'b1, m_err = 1'b0;

    always #5 clock = ~clock;

    mb_addr_tracker dut (
        .clock(clock),
        .reset(reset),
        .Slice_Start_I(Slice_Start_I),
        .Slice_Vert_Pos_I(Slice_Vert_Pos_I),
        .MB_Width_I(MB_Width_I),
        .Pic_MB_Count_I(Pic_MB_Count_I),
        .Incr_Req_I(Incr_Req_I),
        .Incr_Start_O(Incr_Start_O),
        .Valid_Code_I(Valid_Code_I),
        .Symbol_I(Symbol_I),
        .MB_Addr_O(MB_Addr_O),
        .MB_Row_O(MB_Row_O),
        .MB_Col_O(MB_Col_O),
        .Skip_Count_O(Skip_Count_O),
        .Addr_Valid_O(Addr_Valid_O),
        .Addr_Ack_I(Addr_Ack_I),
        .Addr_Err_O(Addr_Err_O)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (Incr_Start_O) starts++;
        if (Addr_Valid_O) begin
            chk("addr", int'(MB_Addr_O), m_addr);
            chk("row", int'(MB_Row_O), exp_row);
            chk("col", int'(MB_Col_O), exp_col);
            chk("skip", int'(Skip_Count_O), exp_skip);
            chk("err", int'(Addr_Err_O), int'(m_err));
        end
    end

    // Absolute address arithmetic; row/col from division of the unclamped address.
    task automatic model(input int incr);
        int a;
        a = m_first ? (m_vpos - 1) * m_width + incr - 1 : m_addr + incr;
        exp_skip = m_first ? 0 : incr - 1;
        exp_row = a / m_width;
        exp_col = a % m_width;
`ifdef MB_ADDR_RANGE_CHECK_EN
        if (a >= m_pic) begin
            a = m_pic - 1;
            m_err = 1'b1;
        end
`endif
        m_addr = a;
    endtask

    task automatic slice(input int v);
        Slice_Start_I = 1'b1;
        Slice_Vert_Pos_I = 8'(v);
        @(posedge clock); #1;
        Slice_Start_I = 1'b0;
        m_vpos = v;
        m_first = 1'b1;
        m_err = 1'b0;
    endtask

    task automatic code(input logic [7:0] s, input bit junk);
        int n = 0;
        while (!Incr_Start_O && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk("start_seen", int'(Incr_Start_O), 1);
        if (junk) begin
            Valid_Code_I = 1'b1;
            Symbol_I = 8'h85;
        end
        @(posedge clock); #1;
        Valid_Code_I = 1'b0;
        @(posedge clock); #1;
        Valid_Code_I = 1'b1;
        Symbol_I = s;
        @(posedge clock); #1;
        Valid_Code_I = 1'b0;
    endtask

    task automatic mb(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input int n,
                      input bit req, input bit junk, input bit chain, input int la, input int ls);
        logic [7:0] s [3];
        int incr = 0;
        int lat = 0;
        int st;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        for (int i = 0; i < n; i++) begin
            int v = int'(s[i][5:0]);
            incr += v == 34 ? 33 : v == 35 ? 0 : (v == 0 || v > 35) ? 1 : v;
            if (v == 0 || v > 35) m_err = 1'b1;
        end
        model(incr);
        st = starts;
        if (req) begin
            Incr_Req_I = 1'b1;
            @(posedge clock); #1;
            Incr_Req_I = 1'b0;
        end
        for (int i = 0; i < n; i++) code(s[i], junk && i == 0);
        while (!Addr_Valid_O && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", lat + 1, incr + 1);
        chk("start_pulses", starts - st, n);
        if (la >= 0) chk("lit_addr", int'(MB_Addr_O), la);
        if (ls >= 0) chk("lit_skip", int'(Skip_Count_O), ls);
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("valid_hold", int'(Addr_Valid_O), 1);
        Addr_Ack_I = 1'b1;
        Incr_Req_I = chain;
        @(posedge clock); #1;
        Addr_Ack_I = 1'b0;
        Incr_Req_I = 1'b0;
        chk("valid_drop", int'(Addr_Valid_O), 0);
        if (chain) chk("chain_start", int'(Incr_Start_O), 1);
        m_first = 1'b0;
    endtask

    initial begin
        int st;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_addr", int'(MB_Addr_O), 0);
        chk("rst_row", int'(MB_Row_O), 0);
        chk("rst_col", int'(MB_Col_O), 0);
        chk("rst_skip", int'(Skip_Count_O), 0);
        chk("rst_valid", int'(Addr_Valid_O), 0);
        chk("rst_start", int'(Incr_Start_O), 0);
        chk("rst_err", int'(Addr_Err_O), 0);
        MB_Width_I = 7'd45;
        Pic_MB_Count_I = 14'd8160;
        slice(3);
        mb(8'h81, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 90, 0);
        chk("lit_row_first", exp_row, 2);
        mb(8'h85, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 95, 4);
        chk("lit_col_second", exp_col, 5);
        mb(8'hA2, 8'hA2, 8'h82, 3, 1'b1, 1'b0, 1'b1, 163, 67);
        chk("lit_row_wrap", exp_row, 3);
        chk("lit_col_wrap", exp_col, 28);
        mb(8'hA3, 8'h81, 8'h00, 2, 1'b0, 1'b1, 1'b0, 164, 0);
        Incr_Req_I = 1'b1;
        @(posedge clock); #1;
        Incr_Req_I = 1'b0;
        @(posedge clock); #1;
        slice(3);
        chk("abort_valid", int'(Addr_Valid_O), 0);
        chk("abort_start", int'(Incr_Start_O), 0);
        st = starts;
        Valid_Code_I = 1'b1;
        Symbol_I = 8'h81;
        @(posedge clock); #1;
        Valid_Code_I = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        chk("abort_idle_valid", int'(Addr_Valid_O), 0);
        chk("abort_idle_starts", starts - st, 0);
        mb(8'h83, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 92, 0);
        mb(8'h80, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 93, 0);
        chk("lit_illegal_err", int'(Addr_Err_O), 1);
        slice(3);
        chk("err_clear", int'(Addr_Err_O), 0);
        m_pic = 99;
        Pic_MB_Count_I = 14'd99;
        mb(8'h89, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 98, 0);
`ifdef MB_ADDR_RANGE_CHECK_EN
        mb(8'h83, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 98, 2);
        chk("lit_range_err", int'(Addr_Err_O), 1);
`else
        mb(8'h83, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 101, 2);
        chk("lit_range_err", int'(Addr_Err_O), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
